sprite_render_sequencer: RTL and testbench



---
 rtl/sprite_render_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_sprite_render_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_render_sequencer.sv
// sprite_render_sequencer: frame scheduler for the sprite slots.
// Each frame runs a draw pass, a hold pass and an erase pass. Every pass sends a
// one-cycle pulse to each slot in turn and waits for it. The active slot's pixel
// stream is muxed into one registered plot stream for the VGA adapter.
// Optional build macro RENDER_FRAME_COUNT_EN adds a 16-bit wrapping frame_count output.
module sprite_render_sequencer #(
    parameter int NUM_SPRITES  = 3,
    parameter int PIPE_DELAY   = 3,
    parameter int DRAW_TIMEOUT = 63,
    parameter int ERASE_CYCLES = 44,
    parameter int HOLD_CYCLES  = 833333
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [9*NUM_SPRITES-1:0] sprite_x,
    input  logic [8*NUM_SPRITES-1:0] sprite_y,
    input  logic [3*NUM_SPRITES-1:0] sprite_colour,
    input  logic [NUM_SPRITES-1:0]   sprite_finish,
    output logic [NUM_SPRITES-1:0]   draw_signal,
    output logic [NUM_SPRITES-1:0]   erase_signal,
    output logic [8:0]               vga_x,
    output logic [7:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     plot,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     timeout_err
`ifdef RENDER_FRAME_COUNT_EN
    ,
    output logic [15:0]              frame_count
`endif
);

    localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW_PULSE,
        S_DRAW_WAIT,
        S_HOLD,
        S_ERASE_PULSE,
        S_ERASE_WAIT
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [5:0]          r_wait_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_timeout_err;
    logic                r_plot_p1;
    logic [8:0]          r_vga_x_p1;
    logic [7:0]          r_vga_y_p1;
    logic [2:0]          r_vga_colour_p1;

    state_t              w_next_state;
    logic [IDX_W-1:0]    w_next_idx;
    logic [5:0]          w_next_wait;
    logic [HOLD_W-1:0]   w_next_hold;
    logic                w_set_timeout;
    logic                w_frame_done;
    logic                w_last_slot;
    logic                w_window;
    logic [NUM_SPRITES-1:0] w_onehot;
    logic [8:0]          w_slot_x;
    logic [7:0]          w_slot_y;
    logic [2:0]          w_slot_colour;

    assign w_last_slot   = (r_idx == IDX_W'(NUM_SPRITES - 1));
    assign w_slot_x      = sprite_x[r_idx*9 +: 9];
    assign w_slot_y      = sprite_y[r_idx*8 +: 8];
    assign w_slot_colour = sprite_colour[r_idx*3 +: 3];
    // The sprite pixel pipeline needs PIPE_DELAY cycles after its pulse before data is valid
    assign w_window      = ((r_state == S_DRAW_WAIT) || (r_state == S_ERASE_WAIT)) &&
                           (r_wait_cnt >= 6'(PIPE_DELAY));

    // One-hot decode of the active slot index, shared by draw and erase pulses
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_onehot[i] = (r_idx == IDX_W'(i));
        end
    end

    // Next-state, counter and pulse decode for the frame sequencer
    always_comb begin
        w_next_state  = r_state;
        w_next_idx    = r_idx;
        w_next_wait   = r_wait_cnt;
        w_next_hold   = r_hold_cnt;
        w_set_timeout = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_DRAW_PULSE;
                    w_next_idx   = '0;
                end
            end
            S_DRAW_PULSE: begin
                w_next_wait  = '0;
                w_next_state = S_DRAW_WAIT;
            end
            S_DRAW_WAIT: begin
                w_next_wait = r_wait_cnt + 6'd1;
                if (sprite_finish[r_idx] || (r_wait_cnt == 6'(DRAW_TIMEOUT - 1))) begin
                    // A finish arriving on the timeout cycle still counts as a clean finish
                    w_set_timeout = !sprite_finish[r_idx];
                    if (w_last_slot) begin
                        w_next_hold  = '0;
                        w_next_state = S_HOLD;
                    end else begin
                        w_next_idx   = r_idx + IDX_W'(1);
                        w_next_state = S_DRAW_PULSE;
                    end
                end
            end
            S_HOLD: begin
                w_next_hold = r_hold_cnt + HOLD_W'(1);
                if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_next_idx   = '0;
                    w_next_state = S_ERASE_PULSE;
                end
            end
            S_ERASE_PULSE: begin
                w_next_wait  = '0;
                w_next_state = S_ERASE_WAIT;
            end
            S_ERASE_WAIT: begin
                w_next_wait = r_wait_cnt + 6'd1;
                if (r_wait_cnt == 6'(ERASE_CYCLES - 1)) begin
                    if (w_last_slot) begin
                        // run is only re-examined here, so a mid-frame drop still finishes the erase
                        w_frame_done = 1'b1;
                        w_next_idx   = '0;
                        w_next_state = run ? S_DRAW_PULSE : S_IDLE;
                    end else begin
                        w_next_idx   = r_idx + IDX_W'(1);
                        w_next_state = S_ERASE_PULSE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Sequencer state, slot index, counters and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_wait_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_idx      <= w_next_idx;
            r_wait_cnt <= w_next_wait;
            r_hold_cnt <= w_next_hold;
            if (w_set_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Registered plot stream; coordinates hold their last value outside the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plot_p1       <= 1'b0;
            r_vga_x_p1      <= '0;
            r_vga_y_p1      <= '0;
            r_vga_colour_p1 <= '0;
        end else begin
            r_plot_p1 <= w_window;
            if (w_window) begin
                r_vga_x_p1      <= w_slot_x;
                r_vga_y_p1      <= w_slot_y;
                r_vga_colour_p1 <= (r_state == S_DRAW_WAIT) ? w_slot_colour : 3'b000;
            end
        end
    end

`ifdef RENDER_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_frame_done) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign draw_signal  = (r_state == S_DRAW_PULSE)  ? w_onehot : '0;
    assign erase_signal = (r_state == S_ERASE_PULSE) ? w_onehot : '0;
    assign frame_done   = w_frame_done;
    assign busy         = (r_state != S_IDLE);
    assign timeout_err  = r_timeout_err;
    assign plot         = r_plot_p1;
    assign vga_x        = r_vga_x_p1;
    assign vga_y        = r_vga_y_p1;
    assign vga_colour   = r_vga_colour_p1;

endmodule

// File: tb/tb_sprite_render_sequencer.sv
// Testbench for sprite_render_sequencer with two slots and a short hold pass.
// Each table row describes one frame: stub finish delays, slot pixels and the
// expected draw-wait lengths and timeout flag. A schedule model predicts every
// pulse and pushes expected plot pixels into a queue that is popped as the DUT plots.
module tb_sprite_render_sequencer;

    localparam int NS        = 2;
    localparam int HOLD      = 10;
    localparam int ERASE_LEN = 44;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [17:0] sprite_x;
    logic [15:0] sprite_y;
    logic [5:0]  sprite_colour;
    logic [1:0]  sprite_finish;
    logic [1:0]  draw_signal;
    logic [1:0]  erase_signal;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        frame_done;
    logic        busy;
    logic        timeout_err;
`ifdef RENDER_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    sprite_render_sequencer #(
        .NUM_SPRITES  (NS),
        .PIPE_DELAY   (3),
        .DRAW_TIMEOUT (63),
        .ERASE_CYCLES (ERASE_LEN),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_colour (sprite_colour),
        .sprite_finish (sprite_finish),
        .draw_signal   (draw_signal),
        .erase_signal  (erase_signal),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .plot          (plot),
        .frame_done    (frame_done),
        .busy          (busy),
        .timeout_err   (timeout_err)
`ifdef RENDER_FRAME_COUNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         d0;
        int         d1;
        logic [8:0] x0;
        logic [8:0] x1;
        logic [7:0] y0;
        logic [7:0] y1;
        logic [2:0] c0;
        logic [2:0] c1;
        int         len0;
        int         len1;
        bit         to;
        bit         drop;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    vec_t       rows [7];
    pix_t       q [$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         vi = -1;
    bit         active = 1'b0;
    int         next_cyc = 0;
    int         kind = 0;
    int         busy_from = 0;
    int         drop_cyc = -1;
    int         fc = 0;
    int         cnt [2];
    logic [8:0] last_x = '0;
    logic [7:0] last_y = '0;
    logic [2:0] last_c = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_pix(input int start, input int n, input logic [8:0] x,
                            input logic [7:0] y, input logic [2:0] c);
        pix_t p;
        for (int k = 0; k < n; k++) begin
            p.cyc = start + k;
            p.x   = x;
            p.y   = y;
            p.c   = c;
            q.push_back(p);
        end
    endtask

    task automatic start_sched();
        active    = 1'b1;
        next_cyc  = cyc + 1;
        kind      = 0;
        busy_from = cyc + 1;
    endtask

    task automatic clear_model();
        q.delete();
        last_x   = '0;
        last_y   = '0;
        last_c   = '0;
        active   = 1'b0;
        drop_cyc = -1;
        fc       = 0;
    endtask

    // One clock: compare outputs against the model, advance the schedule, run the sprite stubs.
    task automatic step();
        logic [1:0] eds;
        logic [1:0] ees;
        logic       efd;
        pix_t       p;
        @(negedge clk);
        cyc++;
        eds = '0;
        ees = '0;
        efd = 1'b0;
        if (active && cyc == next_cyc) begin
            case (kind)
                0: eds = 2'b01;
                1: eds = 2'b10;
                2: ees = 2'b01;
                3: ees = 2'b10;
                default: efd = 1'b1;
            endcase
        end
        chk("pulses", {27'd0, draw_signal, erase_signal, frame_done}, {27'd0, eds, ees, efd});
        chk("busy", {31'd0, busy}, {31'd0, (active && cyc >= busy_from)});
        if (q.size() > 0 && q[0].cyc == cyc) begin
            p = q.pop_front();
            last_x = p.x;
            last_y = p.y;
            last_c = p.c;
            chk("plot", {31'd0, plot}, 32'd1);
        end else begin
            chk("plot", {31'd0, plot}, 32'd0);
        end
        chk("vga", {12'd0, vga_x, vga_y, vga_colour}, {12'd0, last_x, last_y, last_c});
`ifdef RENDER_FRAME_COUNT_EN
        chk("frame_count", {16'd0, frame_count}, fc);
`endif
        if (efd) begin
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, rows[vi].to});
            fc++;
        end
        if (active && cyc == next_cyc) begin
            case (kind)
                0: begin
                    vi++;
                    sprite_x      = {rows[vi].x1, rows[vi].x0};
                    sprite_y      = {rows[vi].y1, rows[vi].y0};
                    sprite_colour = {rows[vi].c1, rows[vi].c0};
                    push_pix(cyc + 5, rows[vi].len0 - 3, rows[vi].x0, rows[vi].y0, rows[vi].c0);
                    next_cyc = cyc + rows[vi].len0 + 1;
                    kind = 1;
                end
                1: begin
                    push_pix(cyc + 5, rows[vi].len1 - 3, rows[vi].x1, rows[vi].y1, rows[vi].c1);
                    next_cyc = cyc + rows[vi].len1 + 1 + HOLD;
                    if (rows[vi].drop) drop_cyc = cyc + rows[vi].len1 + 4;
                    kind = 2;
                end
                2: begin
                    push_pix(cyc + 5, ERASE_LEN - 3, rows[vi].x0, rows[vi].y0, 3'b000);
                    next_cyc = cyc + ERASE_LEN + 1;
                    kind = 3;
                end
                3: begin
                    push_pix(cyc + 5, ERASE_LEN - 3, rows[vi].x1, rows[vi].y1, 3'b000);
                    next_cyc = cyc + ERASE_LEN;
                    kind = 4;
                end
                default: begin
                    if (run) begin
                        next_cyc = cyc + 1;
                        kind = 0;
                    end else begin
                        active = 1'b0;
                    end
                end
            endcase
        end
        if (cyc == drop_cyc) run = 1'b0;
        for (int i = 0; i < NS; i++) begin
            sprite_finish[i] = 1'b0;
            if (reset) begin
                cnt[i] = 0;
            end else if (draw_signal[i] && vi >= 0) begin
                cnt[i] = (i == 0) ? rows[vi].d0 : rows[vi].d1;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) sprite_finish[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (active && n < budget) begin
            step();
            n++;
        end
        if (active) begin
            checks++;
            failures++;
            $display("FAIL frame_budget cyc=%0d actual=busy required=idle", cyc);
            clear_model();
        end
    endtask

    initial begin
        // d0 d1 x0 x1 y0 y1 c0 c1 len0 len1 to drop ; d=0 means the stub never finishes
        rows[0] = '{40, 40, 9'd100, 9'd200, 8'd20,  8'd100, 3'b101, 3'b011, 40, 40, 1'b0, 1'b0};
        rows[1] = '{1,  4,  9'd5,   9'd319, 8'd0,   8'd239, 3'b111, 3'b001, 1,  4,  1'b0, 1'b0};
        rows[2] = '{63, 62, 9'd150, 9'd20,  8'd60,  8'd30,  3'b010, 3'b110, 63, 62, 1'b0, 1'b0};
        rows[3] = '{40, 0,  9'd10,  9'd300, 8'd200, 8'd5,   3'b100, 3'b101, 40, 63, 1'b1, 1'b0};
        rows[4] = '{10, 20, 9'd77,  9'd88,  8'd99,  8'd111, 3'b011, 3'b111, 10, 20, 1'b1, 1'b1};
        rows[5] = '{40, 40, 9'd33,  9'd44,  8'd55,  8'd66,  3'b001, 3'b010, 40, 40, 1'b0, 1'b0};
        rows[6] = '{20, 30, 9'd123, 9'd45,  8'd67,  8'd89,  3'b110, 3'b010, 20, 30, 1'b0, 1'b1};

        reset         = 1'b1;
        run           = 1'b0;
        sprite_x      = '0;
        sprite_y      = '0;
        sprite_colour = '0;
        sprite_finish = '0;
        cnt[0] = 0;
        cnt[1] = 0;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        // Rows 0..4 back to back; row 4 drops run during its hold pass
        run = 1'b1;
        start_sched();
        wait_idle(3000);
        repeat (20) step();

        // Row 5: asynchronous reset ten cycles into slot 0 DRAW_WAIT
        run = 1'b1;
        start_sched();
        begin
            int n;
            n = 0;
            while (!(vi == 5 && kind == 1) && n < 600) begin
                step();
                n++;
            end
        end
        repeat (10) step();
        reset = 1'b1;
        #1;
        chk("reset_async", {draw_signal, erase_signal, plot, frame_done, busy, timeout_err,
                            vga_x, vga_y, vga_colour},
            32'd0);
        clear_model();
        repeat (2) step();
        reset = 1'b0;
        start_sched();

        // Row 6 after recovery; drops run in hold and returns to idle
        wait_idle(1000);
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
